// File: rtl/afficheur_scan_ctrl.sv
// afficheur_scan_ctrl: time-multiplexed scan controller for a multi-digit 7-segment display
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   iBcd     packed BCD value, [3:0] = digit 0 (rightmost)
//   iLoad    one-cycle capture strobe for iBcd into the shadow register
//   iEnable  1: scanning, 0: display off
//   oDigit   BCD nibble for the shared 7-segment decoder
//   oSel     digit select lines (one-hot when active, polarity set by POLARITE)
//   oFrame   one-cycle pulse on the last cycle of every full scan
module afficheur_scan_ctrl #(
    parameter int NB_DIGITS = 4,
    parameter int DIV       = 50000,
    parameter int BLANK     = 500,
    parameter int POLARITE  = 1,
    parameter int LZB       = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*NB_DIGITS-1:0] iBcd,
    input  logic                   iLoad,
    input  logic                   iEnable,
    output logic [3:0]             oDigit,
    output logic [NB_DIGITS-1:0]   oSel,
    output logic                   oFrame
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NB_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NB_DIGITS - 1);
    localparam logic [NB_DIGITS-1:0] SEL_OFF = (POLARITE != 0) ? '1 : '0;

    typedef enum logic [1:0] {IDLE, DEAD, SHOW} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*NB_DIGITS-1:0] shadow_q, shadow_d, disp_q, disp_d;
    logic                   pend_q, pend_d;
    logic [3:0]             digit_q, digit_d;
    logic [NB_DIGITS-1:0]   sel_q, sel_d;
    logic                   frame_q, frame_d;
    logic [NB_DIGITS-1:0]   lz;
    logic [NB_DIGITS-1:0]   onehot;
    logic                   frame_end, xfer, blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            digit_q  <= '0;
            sel_q    <= SEL_OFF;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            digit_q  <= digit_d;
            sel_q    <= sel_d;
            frame_q  <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        if (!iEnable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = DEAD;
                    cnt_d   = '0;
                end
                DEAD: if (cnt_q == CNT_BLANK) state_d = SHOW;
                default: if (cnt_q == CNT_LAST) begin
                    state_d = DEAD;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            endcase
        end
    end

    // Shadow is only copied to the display at a frame boundary (or any time
    // while idle), so a visible frame always comes from a single value.
    always_comb begin
        frame_end = (state_q == SHOW) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
        xfer      = pend_q && ((state_q == IDLE) || frame_end);
        disp_d    = xfer ? shadow_q : disp_q;
        shadow_d  = iLoad ? iBcd : shadow_q;
        pend_d    = iLoad ? 1'b1 : (xfer ? 1'b0 : pend_q);
    end

    // Outputs are computed from next-state values and registered, so the
    // registered outputs line up with the registered state.
    always_comb begin
        lz[NB_DIGITS-1] = disp_d[4*NB_DIGITS-1 -: 4] == 4'd0;
        for (int i = NB_DIGITS - 2; i >= 0; i--)
            lz[i] = lz[i+1] && (disp_d[4*i +: 4] == 4'd0);
        blank   = (LZB != 0) && (idx_d != '0) && lz[idx_d];
        onehot  = {{(NB_DIGITS-1){1'b0}}, 1'b1} << idx_d;
        digit_d = disp_d[{idx_d, 2'b00} +: 4];
        sel_d   = (state_d == SHOW && !blank) ? ((POLARITE != 0) ? ~onehot : onehot) : SEL_OFF;
        frame_d = (state_d == SHOW) && (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end

    assign oDigit = digit_q;
    assign oSel   = sel_q;
    assign oFrame = frame_q;
endmodule
